// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation datapath.
// Holds the P-192 prime modulus and the state encodings used by
// mod_exp (exponent scan / square-and-multiply control) and mod_mul
// (bit-serial modular multiplier).
package rsa_pkg;

  localparam int P192_W = 192;

  // NIST P-192 prime: 2^192 - 2^64 - 1
  localparam logic [P192_W-1:0] P192_M =
    192'hfffffffffffffffffffffffffffffffeffffffffffffffff;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    SQR,
    MUL,
    FIN
  } exp_state_e;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_DONE
  } mul_state_e;

endpackage

// File: rtl/mod_mul.sv
// Interleaved modular multiplier: p = x*y mod m.
// Consumes two bits of y per cycle (MSB first), so one product takes
// WIDTH/2 run cycles plus one cycle to register the request. WIDTH must
// be even.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   start  - accepted only when idle; x/y are latched on acceptance
//   x, y   - operands, both required to be < m
//   done   - one-cycle pulse, p valid in the same cycle
//   p      - product mod m
module mod_mul
  import rsa_pkg::*;
#(
  parameter int               WIDTH = 192,
  parameter logic [WIDTH-1:0] m     = P192_M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);
  localparam logic [WIDTH+1:0] MX = {2'b00, m};

  mul_state_e       st_q,  st_d;
  logic [WIDTH-1:0] x_q,   x_d;
  logic [WIDTH-1:0] y_q,   y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One radix-2 step: acc*2 + bit*x stays below 3m (acc, x < m), so two
  // conditional subtractions always bring it back under m.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] a,
                                            input logic             yb,
                                            input logic [WIDTH-1:0] xv);
    logic [WIDTH+1:0] t;
    t = {1'b0, a, 1'b0} + (yb ? {2'b00, xv} : '0);
    if (t >= MX) t = t - MX;
    if (t >= MX) t = t - MX;
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (st_q)
      MM_IDLE: if (start) begin
        x_d   = x;
        y_d   = y;
        acc_d = '0;
        cnt_d = '0;
        st_d  = MM_RUN;
      end
      MM_RUN: begin
        acc_d = step(step(acc_q, y_q[WIDTH-1], x_q), y_q[WIDTH-2], x_q);
        y_d   = y_q << 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) st_d = MM_DONE;
      end
      MM_DONE: st_d = MM_IDLE;
      default: st_d = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= MM_IDLE;
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (st_q == MM_DONE);
  assign p    = acc_q;

endmodule

// File: rtl/mod_exp.sv
// Modular exponentiation: result = base^exp mod M, left-to-right binary
// square-and-multiply around a single mod_mul instance.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, aborts any operation
//   start  - request, sampled only in IDLE
//   base   - base operand, latched on accepted start
//   exp    - exponent, latched on accepted start
//   result - base^exp mod M, held from done until the next accepted start
//   done   - one-cycle completion pulse
//   busy   - high from the cycle after start until the done cycle
module mod_exp
  import rsa_pkg::*;
#(
  parameter int               WIDTH = 192,
  parameter logic [WIDTH-1:0] M     = P192_M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);

  exp_state_e       state_q,     state_d;
  logic [WIDTH-1:0] base_q,      base_d;
  logic [WIDTH-1:0] exp_q,       exp_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [IW-1:0]    idx_q,       idx_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             done_q,      done_d;
  logic             mul_start_q, mul_start_d;

  logic             rst_n;
  logic             mul_done;
  logic [WIDTH-1:0] mul_y;
  logic [WIDTH-1:0] mul_p;

  assign rst_n = ~rst;
  assign mul_y = (state_q == MUL) ? b_q : acc_q;

  mod_mul #(.WIDTH(WIDTH), .m(M)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start_q),
    .x     (acc_q),
    .y     (mul_y),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    done_d   = 1'b0;
    // Request held until mul_done; dropping it on done and re-raising it
    // only after a cycle in the next state gives the mandatory low gap.
    mul_start_d = ((state_q == SQR) || (state_q == MUL)) && !mul_done;
    case (state_q)
      IDLE: if (start) begin
        base_d  = base;
        exp_d   = exp;
        state_d = LOAD;
      end
      LOAD: begin
        // M > 2^(WIDTH-1), so a single subtraction fully reduces base.
        b_d     = (base_q >= M) ? base_q - M : base_q;
        acc_d   = WIDTH'(1);
        idx_d   = IW'(WIDTH - 1);
        state_d = SCAN;
      end
      SCAN: begin
        if (exp_q[idx_q]) begin
          acc_d = b_q;
          if (idx_q == '0) state_d = FIN;
          else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQR;
          end
        end else if (idx_q == '0) state_d = FIN;
        else idx_d = idx_q - 1'b1;
      end
      SQR: if (mul_done) begin
        acc_d = mul_p;
        if (exp_q[idx_q]) state_d = MUL;
        else if (idx_q == '0) state_d = FIN;
        else begin
          idx_d   = idx_q - 1'b1;
          state_d = SQR;
        end
      end
      MUL: if (mul_done) begin
        acc_d = mul_p;
        if (idx_q == '0) state_d = FIN;
        else begin
          idx_d   = idx_q - 1'b1;
          state_d = SQR;
        end
      end
      FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      exp_q       <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      done_q      <= done_d;
      mul_start_q <= mul_start_d;
    end
  end

  // done/result are registered out of FIN, so the pulse lands in IDLE and
  // busy is extended through it.
  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE) || done_q;

endmodule
